// File: rtl/mont_exp_pkg.sv
// mont_exp_pkg: shared state encoding and default widths for the Montgomery exponentiation sequencer.
package mont_exp_pkg;
   localparam int DEF_WIDTH     = 1024;
   localparam int DEF_EXP_WIDTH = 1024;
   localparam int DEF_TW        = $clog2(DEF_EXP_WIDTH + 1);
   typedef enum logic [3:0] {
      IDLE, PRE, WPRE, SQR, WSQR, MUL, WMUL, NXT, POST, WPOST, DONE
   } state_t;
endpackage

// File: rtl/mont_exp_ctrl_mm_issue.sv
// mm_issue: one-cycle multiplier start pulse and completion ack for a single outstanding multiplication.
module mm_issue (
   input  logic clk,
   input  logic resetn,
   input  logic go,
   input  logic mm_done,
   output logic mm_start,
   output logic ack
);
   logic waiting;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mm_start <= 1'b0;
         waiting  <= 1'b0;
      end else begin
         mm_start <= go;
         waiting  <= go | (waiting & ~mm_done);
      end
   end
   // completions arriving with nothing outstanding are dropped here
   assign ack = waiting & mm_done;
endmodule

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
module mont_exp_ctrl
   import mont_exp_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int EXP_WIDTH = DEF_EXP_WIDTH,
   parameter int TW        = $clog2(EXP_WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [EXP_WIDTH-1:0] in_e,
   input  logic [TW-1:0]        in_t,
   input  logic [WIDTH-1:0]     in_m,
   input  logic [WIDTH-1:0]     in_r,
   input  logic [WIDTH-1:0]     in_r2,
   output logic [WIDTH-1:0]     result,
   output logic                 done,
   output logic                 busy,
   output logic                 mm_start,
   output logic [WIDTH-1:0]     mm_a,
   output logic [WIDTH-1:0]     mm_b,
   output logic [WIDTH-1:0]     mm_m,
   input  logic [WIDTH-1:0]     mm_result,
   input  logic                 mm_done
);
   state_t               state, nextState;
   logic [EXP_WIDTH-1:0] eReg, eShift;
   logic [TW-1:0]        tReg, idx;
   logic [WIDTH-1:0]     xReg, r2Reg, aReg, xtReg;
   logic                 go, ack;

   assign go     = state inside {PRE, SQR, MUL, POST};
   assign done   = state == DONE;
   assign busy   = !(state inside {IDLE, DONE});
   assign eShift = eReg >> idx;

   mm_issue issue (
      .clk     (clk),
      .resetn  (resetn),
      .go      (go),
      .mm_done (mm_done),
      .mm_start(mm_start),
      .ack     (ack)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = PRE;
         PRE:     nextState = WPRE;
         WPRE:    if (ack) nextState = (tReg != '0) ? SQR : POST;
         SQR:     nextState = WSQR;
         WSQR:    if (ack) nextState = eShift[0] ? MUL : NXT;
         MUL:     nextState = WMUL;
         WMUL:    if (ack) nextState = NXT;
         NXT:     nextState = (idx == '0) ? POST : SQR;
         POST:    nextState = WPOST;
         WPOST:   if (ack) nextState = DONE;
         default: nextState = IDLE;
      endcase
   end

   // A starts as R mod M, the Montgomery form of 1
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         eReg   <= '0;
         tReg   <= '0;
         idx    <= '0;
         xReg   <= '0;
         r2Reg  <= '0;
         aReg   <= '0;
         xtReg  <= '0;
         mm_a   <= '0;
         mm_b   <= '0;
         mm_m   <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               eReg  <= in_e;
               tReg  <= in_t;
               idx   <= in_t - TW'(1);
               mm_m  <= in_m;
               xReg  <= in_x;
               r2Reg <= in_r2;
               aReg  <= in_r;
            end
            PRE: begin
               mm_a <= xReg;
               mm_b <= r2Reg;
            end
            WPRE: if (ack) xtReg <= mm_result;
            SQR: begin
               mm_a <= aReg;
               mm_b <= aReg;
            end
            MUL: begin
               mm_a <= aReg;
               mm_b <= xtReg;
            end
            WSQR, WMUL: if (ack) aReg <= mm_result;
            NXT: if (idx != '0) idx <= idx - TW'(1);
            POST: begin
               mm_a <= aReg;
               mm_b <= WIDTH'(1);
            end
            WPOST: if (ack) result <= mm_result;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl: directed and randomised checks of mont_exp_ctrl against plain modular arithmetic.
module tb_mont_exp_ctrl;
   localparam int W = 8, EW = 8, TWB = 4;
   logic           clk = 1'b0, resetn = 1'b0, start = 1'b0;
   logic [W-1:0]   in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
   logic [EW-1:0]  in_e = '0;
   logic [TWB-1:0] in_t = '0;
   logic [W-1:0]   result, mm_a, mm_b, mm_m;
   logic [W-1:0]   mm_result = '0;
   logic           done, busy, mm_start;
   logic           mm_done = 1'b0;
   int total = 0, passed = 0;
   int startCnt = 0, doneCnt = 0, unstable = 0;
   bit latRand = 1'b0;
   bit pend = 1'b0;
   int cnt = 0;
   logic [W-1:0] ma = '0, mb = '0, mmod = '0;

   mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .TW(TWB)) dut (
      .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e), .in_t(in_t),
      .in_m(in_m), .in_r(in_r), .in_r2(in_r2), .result(result), .done(done), .busy(busy),
      .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
      .mm_result(mm_result), .mm_done(mm_done)
   );

   always #5 clk = ~clk;

   function automatic int rinv(int m);
      for (int k = 1; k < m; k++) if ((k * 256) % m == 1) return k;
      return 0;
   endfunction

   function automatic int mont(int a, int b, int m);
      return (((a * b) % m) * rinv(m)) % m;
   endfunction

   function automatic int modexp(int x, int e, int t, int m);
      int r = 1 % m, p = x % m;
      for (int i = 0; i < t; i++) begin
         if (((e >> i) & 1) == 1) r = (r * p) % m;
         p = (p * p) % m;
      end
      return r;
   endfunction

   // multiplier model: returns a*b*R^-1 mod M a fixed or random number of cycles after start
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend    <= 1'b0;
         cnt     <= 0;
         mm_done <= 1'b0;
      end else begin
         mm_done <= 1'b0;
         if (done) doneCnt <= doneCnt + 1;
         if (pend) begin
            if (mm_a !== ma || mm_b !== mb || mm_m !== mmod) unstable <= unstable + 1;
            if (cnt <= 1) begin
               mm_done   <= 1'b1;
               mm_result <= W'(mont(int'(ma), int'(mb), int'(mmod)));
               pend      <= 1'b0;
            end else cnt <= cnt - 1;
         end
         if (mm_start) begin
            pend     <= 1'b1;
            ma       <= mm_a;
            mb       <= mm_b;
            mmod     <= mm_m;
            cnt      <= latRand ? int'($urandom_range(1, 20)) : 5;
            startCnt <= startCnt + 1;
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic load(input int x, input int e, input int t, input int m);
      in_x  = W'(x);
      in_e  = EW'(e);
      in_t  = TWB'(t);
      in_m  = W'(m);
      in_r  = W'(256 % m);
      in_r2 = W'((256 * 256) % m);
   endtask

   task automatic checkRun(input string tag, input int x, input int e, input int t, input int m,
                           input bit spam);
      int s0 = startCnt, d0 = doneCnt, u0 = unstable, res = -1, exp, ones = 0;
      bit got = 1'b0;
      exp = modexp(x, e, t, m);
      for (int i = 0; i < t; i++) ones += (e >> i) & 1;
      load(x, e, t, m);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 5000 && !got; c++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            res = int'(result);
         end else if (spam) begin
            start = 1'($urandom_range(0, 1));
            in_x  = W'($urandom);
            in_e  = EW'($urandom);
            in_t  = TWB'($urandom_range(0, 8));
            in_m  = W'($urandom);
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, int'(got), 1);
      check({tag, "_result"}, res, exp);
      repeat (3) @(negedge clk);
      check({tag, "_result_held"}, int'(result), exp);
      check({tag, "_done_pulses"}, doneCnt - d0, 1);
      check({tag, "_mults"}, startCnt - s0, 2 + t + ones);
      check({tag, "_stable"}, unstable - u0, 0);
   endtask

   initial begin
      int s0;
      repeat (2) @(negedge clk);
      check("rst_result", int'(result), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_mm_start", int'(mm_start), 0);
      check("rst_mm_a", int'(mm_a), 0);
      check("rst_mm_b", int'(mm_b), 0);
      check("rst_mm_m", int'(mm_m), 0);
      resetn = 1'b1;
      @(negedge clk);

      checkRun("s1", 5, 3, 2, 241, 1'b0);
      check("s1_const", int'(result), 125);
      checkRun("s2", 7, 'b1011, 4, 241, 1'b0);
      check("s2_const", int'(result), 68);
      checkRun("s3_t0", 9, 'hFF, 0, 241, 1'b0);
      checkRun("s4_spam", 5, 3, 2, 241, 1'b1);
      check("s4_const", int'(result), 125);

      // abort during the first squaring: PRE and SQR issued, SQR still outstanding
      s0 = startCnt;
      load(7, 'b1011, 4, 241);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && startCnt < s0 + 2; c++) @(negedge clk);
      check("s5_reach_wsqr", startCnt - s0, 2);
      check("s5_busy_before", int'(busy), 1);
      #1 resetn = 1'b0;
      #1;
      check("s5_rst_result", int'(result), 0);
      check("s5_rst_busy", int'(busy), 0);
      check("s5_rst_done", int'(done), 0);
      check("s5_rst_mm_start", int'(mm_start), 0);
      check("s5_rst_mm_a", int'(mm_a), 0);
      check("s5_rst_mm_b", int'(mm_b), 0);
      check("s5_rst_mm_m", int'(mm_m), 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checkRun("s5_again", 7, 'b1011, 4, 241, 1'b0);

      checkRun("full_t8", 254, 'hFF, 8, 255, 1'b0);

      latRand = 1'b1;
      for (int n = 0; n < 12; n++) begin
         int m = int'($urandom_range(1, 127)) * 2 + 1;
         checkRun("s6_rand", int'($urandom_range(0, m - 1)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 8)), m, n[0]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
